// File: rtl/rr_pointer_arbiter.sv
// rr_pointer_arbiter
//   Single-grant round-robin arbiter with an iSLIP-style pointer. An
//   arbitration is started from IDLE with req_valid. The grant is held until the
//   consumer responds. The pointer only advances past the granted requester when
//   the grant is accepted in the first iteration.
//
// Parameters
//   N     number of requesters
//   IDXW  index width, 2**IDXW >= N
//
// Ports
//   clk           clock, all state updates on the rising edge
//   rst           synchronous active-high reset
//   req_valid     start an arbitration with req (ignored outside IDLE)
//   req[N]        request vector
//   first_iter    first iSLIP iteration flag, sampled with req
//   grant_valid   grant / grant_idx are valid
//   grant[N]      one-hot grant (zero when not valid)
//   grant_idx     binary index of grant (zero when not valid)
//   resp_valid    consumer answered the grant (ignored in IDLE)
//   resp_accept   grant accepted, qualified by resp_valid
//   ptr           round-robin pointer, 0..N-1
//   accept_count  accepted-grant counter, saturating
//
// Build option
//   RR_ARB_ACCEPT_CNT_EN  when defined, accept_count counts accepted grants;
//                         otherwise it is tied to zero and no counter exists.

module rr_pointer_arbiter #(
    parameter int N    = 25,
    parameter int IDXW = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    input  logic [N-1:0]    req,
    input  logic            first_iter,
    output logic            grant_valid,
    output logic [N-1:0]    grant,
    output logic [IDXW-1:0] grant_idx,
    input  logic            resp_valid,
    input  logic            resp_accept,
    output logic [IDXW-1:0] ptr,
    output logic [15:0]     accept_count
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    grant_q, grant_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [IDXW-1:0] ptr_q, ptr_d;
    logic            first_q, first_d;

    logic [31:0]     ptr_ext;
    logic            masked_hit, any_hit;
    logic [IDXW-1:0] masked_idx, any_idx, pick_idx;
    logic [N-1:0]    pick_onehot;

    assign ptr_ext = 32'(ptr_q);

    // Lowest set bit at or above the pointer, falling back to the lowest set
    // bit overall when nothing is requesting at or above the pointer.
    always_comb begin
        masked_hit = 1'b0;
        masked_idx = '0;
        any_hit    = 1'b0;
        any_idx    = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (req[i] && !any_hit) begin
                any_hit = 1'b1;
                any_idx = IDXW'(i);
            end
            if (req[i] && (i >= ptr_ext) && !masked_hit) begin
                masked_hit = 1'b1;
                masked_idx = IDXW'(i);
            end
        end
        pick_idx = masked_hit ? masked_idx : any_idx;
    end

    always_comb begin
        pick_onehot = '0;
        for (int unsigned i = 0; i < N; i++) begin
            pick_onehot[i] = (IDXW'(i) == pick_idx);
        end
    end

    // Next-state and next-register logic.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        first_d = first_q;
        case (state_q)
            IDLE: begin
                if (req_valid && (|req)) begin
                    state_d = GRANT;
                    grant_d = pick_onehot;
                    idx_d   = pick_idx;
                    first_d = first_iter;
                end
            end
            GRANT: begin
                if (resp_valid) begin
                    state_d = IDLE;
                    grant_d = '0;
                    idx_d   = '0;
                    if (resp_accept && first_q) begin
                        ptr_d = (idx_q == IDXW'(N - 1)) ? '0 : idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            first_q <= first_d;
        end
    end

    assign grant_valid = (state_q == GRANT);
    assign grant       = grant_q;
    assign grant_idx   = idx_q;
    assign ptr         = ptr_q;

`ifdef RR_ARB_ACCEPT_CNT_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if ((state_q == GRANT) && resp_valid && resp_accept && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign accept_count = cnt_q;
`else
    assign accept_count = '0;
`endif

endmodule

// File: tb/tb_rr_pointer_arbiter.sv
module tb_rr_pointer_arbiter;

    localparam int N    = 25;
    localparam int IDXW = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            req_valid;
    logic [N-1:0]    req;
    logic            first_iter;
    logic            grant_valid;
    logic [N-1:0]    grant;
    logic [IDXW-1:0] grant_idx;
    logic            resp_valid;
    logic            resp_accept;
    logic [IDXW-1:0] ptr;
    logic [15:0]     accept_count;

    rr_pointer_arbiter #(.N(N), .IDXW(IDXW)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req          (req),
        .first_iter   (first_iter),
        .grant_valid  (grant_valid),
        .grant        (grant),
        .grant_idx    (grant_idx),
        .resp_valid   (resp_valid),
        .resp_accept  (resp_accept),
        .ptr          (ptr),
        .accept_count (accept_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int m_ptr   = 0;
    int m_cnt   = 0;
    int m_idx   = 0;
    bit m_first = 0;

`ifdef RR_ARB_ACCEPT_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    // Round-robin pick: scan upward from the pointer, wrapping around.
    function automatic int model_pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            int j;
            j = (p + k) % N;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int idx);
        logic [N-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Stimulus helpers: entered and left on a falling edge.
    task automatic start_arb(input logic [N-1:0] r, input logic fi);
        req        = r;
        req_valid  = 1'b1;
        first_iter = fi;
        @(negedge clk);
        req_valid  = 1'b0;
        if (r != '0) begin
            m_idx   = model_pick(r, m_ptr);
            m_first = fi;
        end
    endtask

    task automatic respond(input logic acc);
        resp_valid  = 1'b1;
        resp_accept = acc;
        @(negedge clk);
        resp_valid  = 1'b0;
        resp_accept = 1'b0;
        if (acc) begin
            if (m_first) m_ptr = (m_idx + 1) % N;
            if (CNT_EN && m_cnt < 16'hFFFF) m_cnt++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst   = 1'b0;
        m_ptr = 0;
        m_cnt = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (grant_valid !== 1'b0) begin n_bad++; $display("FAIL reset_gv got %b want 0", grant_valid); end
        n_cmp++;
        if (grant !== '0) begin n_bad++; $display("FAIL reset_grant got %h want 0", grant); end
        n_cmp++;
        if (grant_idx !== '0) begin n_bad++; $display("FAIL reset_idx got %0d want 0", grant_idx); end
        n_cmp++;
        if (ptr !== '0) begin n_bad++; $display("FAIL reset_ptr got %0d want 0", ptr); end
        n_cmp++;
        if (accept_count !== 16'd0) begin n_bad++; $display("FAIL reset_cnt got %0d want 0", accept_count); end
    endtask

    task automatic test_directed();
        logic [N-1:0] r11;
        logic [N-1:0] rtop;
        int exp_idx [4] = '{0, 4, 0, 24};
        int exp_ptr [4] = '{1, 5, 5, 0};
        bit acc     [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        r11  = 25'h0000011;
        rtop = 25'h1000000;
        do_reset();
        for (int s = 0; s < 4; s++) begin
            start_arb((s == 3) ? rtop : r11, 1'b1);
            n_cmp++;
            if (grant_valid !== 1'b1 || grant_idx !== IDXW'(exp_idx[s]) || grant !== onehot(exp_idx[s])) begin
                n_bad++;
                $display("FAIL dir_grant[%0d] got gv=%b idx=%0d grant=%h want gv=1 idx=%0d", s, grant_valid, grant_idx, grant, exp_idx[s]);
            end
            respond(acc[s]);
            n_cmp++;
            if (ptr !== IDXW'(exp_ptr[s]) || grant_valid !== 1'b0 || grant !== '0) begin
                n_bad++;
                $display("FAIL dir_ptr[%0d] got ptr=%0d gv=%b grant=%h want ptr=%0d gv=0 grant=0", s, ptr, grant_valid, grant, exp_ptr[s]);
            end
        end
    endtask

    task automatic test_hold();
        logic [N-1:0] r;
        logic [31:0]  rnd;
        int           held;
        r = 25'h0A50000;
        start_arb(r, 1'b0);
        held = model_pick(r, m_ptr);
        for (int c = 0; c < 3; c++) begin
            rnd       = $urandom;
            req       = rnd[N-1:0];
            req_valid = rnd[31];
            @(negedge clk);
            n_cmp++;
            if (grant_valid !== 1'b1 || grant_idx !== IDXW'(held) || grant !== onehot(held)) begin
                n_bad++;
                $display("FAIL hold[%0d] got gv=%b idx=%0d want gv=1 idx=%0d", c, grant_valid, grant_idx, held);
            end
        end
        // Accept with first_iter=0 while a new request arrives in the same cycle.
        req       = 25'h1FFFFFF;
        req_valid = 1'b1;
        respond(1'b1);
        req_valid = 1'b0;
        n_cmp++;
        if (grant_valid !== 1'b0 || ptr !== IDXW'(m_ptr)) begin
            n_bad++;
            $display("FAIL hold_release got gv=%b ptr=%0d want gv=0 ptr=%0d", grant_valid, ptr, m_ptr);
        end
        @(negedge clk);
        n_cmp++;
        if (grant_valid !== 1'b0) begin n_bad++; $display("FAIL same_cycle_req got gv=%b want 0", grant_valid); end
        // Response while idle must be ignored.
        resp_valid  = 1'b1;
        resp_accept = 1'b1;
        @(negedge clk);
        resp_valid  = 1'b0;
        resp_accept = 1'b0;
        n_cmp++;
        if (grant_valid !== 1'b0 || ptr !== IDXW'(m_ptr) || accept_count !== 16'(m_cnt)) begin
            n_bad++;
            $display("FAIL idle_resp got gv=%b ptr=%0d cnt=%0d want gv=0 ptr=%0d cnt=%0d", grant_valid, ptr, accept_count, m_ptr, m_cnt);
        end
    endtask

    task automatic test_zero_req_and_reset();
        start_arb('0, 1'b1);
        n_cmp++;
        if (grant_valid !== 1'b0 || ptr !== IDXW'(m_ptr)) begin
            n_bad++;
            $display("FAIL zero_req got gv=%b ptr=%0d want gv=0 ptr=%0d", grant_valid, ptr, m_ptr);
        end
        start_arb(25'h0000100, 1'b1);
        n_cmp++;
        if (grant_valid !== 1'b1) begin n_bad++; $display("FAIL pre_rst_grant got gv=%b want 1", grant_valid); end
        // Reset wins over an accepting response in the same cycle.
        rst         = 1'b1;
        resp_valid  = 1'b1;
        resp_accept = 1'b1;
        @(negedge clk);
        rst         = 1'b0;
        resp_valid  = 1'b0;
        resp_accept = 1'b0;
        m_ptr = 0;
        m_cnt = 0;
        n_cmp++;
        if (grant_valid !== 1'b0 || grant !== '0 || grant_idx !== '0 || ptr !== '0 || accept_count !== 16'd0) begin
            n_bad++;
            $display("FAIL rst_mid_grant got gv=%b grant=%h idx=%0d ptr=%0d cnt=%0d want all 0", grant_valid, grant, grant_idx, ptr, accept_count);
        end
    endtask

    task automatic test_count();
        bit pattern [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        do_reset();
        for (int k = 0; k < 5; k++) begin
            start_arb(25'h0000C30, k[0]);
            respond(pattern[k]);
        end
        n_cmp++;
        if (accept_count !== (CNT_EN ? 16'd3 : 16'd0)) begin
            n_bad++;
            $display("FAIL accept_count got %0d want %0d", accept_count, CNT_EN ? 3 : 0);
        end
    endtask

    task automatic test_random();
        logic [31:0]  a, b;
        logic [N-1:0] r;
        int           waits;
        int           e;
        do_reset();
        for (int it = 0; it < 300; it++) begin
            a = $urandom;
            b = $urandom;
            case (b[1:0])
                2'd0: r = a[N-1:0] & b[N+6:7];
                2'd1: r = onehot(a % N);
                2'd2: r = (b[30:27] == 4'd0) ? '0 : a[N-1:0];
                default: r = a[N-1:0];
            endcase
            e = model_pick(r, m_ptr);
            start_arb(r, b[2]);
            if (r == '0) begin
                n_cmp++;
                if (grant_valid !== 1'b0 || grant !== '0) begin
                    n_bad++;
                    $display("FAIL rnd_zero[%0d] got gv=%b grant=%h want gv=0", it, grant_valid, grant);
                end
                continue;
            end
            waits = int'(b[4:3]);
            for (int w = 0; w < waits; w++) begin
                req       = r ^ a[N+6:7];
                req_valid = a[w];
                @(negedge clk);
            end
            req_valid = 1'b0;
            n_cmp++;
            if (grant_valid !== 1'b1 || grant_idx !== IDXW'(e) || grant !== onehot(e)) begin
                n_bad++;
                $display("FAIL rnd_grant[%0d] got gv=%b idx=%0d grant=%h want idx=%0d", it, grant_valid, grant_idx, grant, e);
            end
            respond(b[5] | b[6]);
            n_cmp++;
            if (ptr !== IDXW'(m_ptr) || accept_count !== 16'(m_cnt) || grant_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL rnd_resp[%0d] got ptr=%0d cnt=%0d gv=%b want ptr=%0d cnt=%0d gv=0", it, ptr, accept_count, grant_valid, m_ptr, m_cnt);
            end
        end
    endtask

    initial begin
        rst         = 1'b1;
        req_valid   = 1'b0;
        req         = '0;
        first_iter  = 1'b0;
        resp_valid  = 1'b0;
        resp_accept = 1'b0;
        @(negedge clk);
        test_reset();
        test_directed();
        test_hold();
        test_zero_req_and_reset();
        test_count();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
